rst_ctrl: RTL and testbench

Reset sequencer for the FPGA SoC wrapper. It replaces the free-running reset counter with a controlled sequence:

- waits for PLL lock;
- debounces the pushbutton;
- holds the Cortex-M3 power-on reset (PORESETn) and then the system reset (SYSRESETn) for programmable lengths;
- services CPU-requested warm resets (SYSRESETREQ, LOCKUP) without disturbing the debug domain.

It sits between the PLL/pushbutton and the cm3_min_soc reset inputs, and reports the cause of the last reset.

---
 rtl/rst_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rst_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rst_ctrl.sv
// Reset sequencer: waits for PLL lock, debounces the pushbutton, sequences PORESETn/SYSRESETn
// and services CPU warm-reset requests, reporting the cause of the last reset.
module rst_ctrl #(
  parameter int unsigned LOCK_CYCLES     = 64,
  parameter int unsigned POR_CYCLES      = 256,
  parameter int unsigned SYS_CYCLES      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter bit          LOCKUP_RST      = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCKED,
  input  logic       BTN,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  output logic       PORESETn,
  output logic       SYSRESETn,
  output logic [4:0] RST_CAUSE
);

  localparam int unsigned CntMax0 = (LOCK_CYCLES > POR_CYCLES) ? LOCK_CYCLES : POR_CYCLES;
  localparam int unsigned CntMax  = (CntMax0 > SYS_CYCLES) ? CntMax0 : SYS_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned DebW    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);
  localparam logic [CntW-1:0] PorLast  = CntW'(POR_CYCLES - 1);
  localparam logic [CntW-1:0] SysLast  = CntW'(SYS_CYCLES - 1);
  localparam logic [DebW-1:0] DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

  localparam logic [4:0] CausePin    = 5'b00001;
  localparam logic [4:0] CauseBtn    = 5'b00010;
  localparam logic [4:0] CausePll    = 5'b00100;
  localparam logic [4:0] CauseSysReq = 5'b01000;
  localparam logic [4:0] CauseLockup = 5'b10000;

  typedef enum logic [2:0] {
    StLockWait,
    StPorHold,
    StSysHold,
    StRun,
    StWarm
  } state_e;

  // Two-flop synchronizers for the asynchronous inputs
  logic lock_meta_q, lock_s;
  logic btn_meta_q, btn_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_meta_q <= 1'b0;
      lock_s      <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_s       <= 1'b0;
    end else begin
      lock_meta_q <= PLL_LOCKED;
      lock_s      <= lock_meta_q;
      btn_meta_q  <= BTN;
      btn_s       <= btn_meta_q;
    end
  end

  // Debouncer: level flips after DEBOUNCE_CYCLES consecutive cycles of disagreement
  logic            deb_q, deb_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            btn_evt_q, btn_evt_d;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    btn_evt_d = 1'b0;
    if (btn_s != deb_q) begin
      if (deb_cnt_q == DebLast) begin
        deb_d     = ~deb_q;
        btn_evt_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      btn_evt_q <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      btn_evt_q <= btn_evt_d;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            por_n_q, por_n_d;
  logic            sys_n_q, sys_n_d;
  logic [4:0]      cause_q, cause_d;
  logic            lockup_req;
  logic            warm_hold;

  assign lockup_req = LOCKUP && LOCKUP_RST;
  assign warm_hold  = SYSRESETREQ || lockup_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    por_n_d = por_n_q;
    sys_n_d = sys_n_q;
    cause_d = cause_q;

    if (state_q != StLockWait && !lock_s) begin
      state_d = StLockWait;
      cnt_d   = '0;
      por_n_d = 1'b0;
      sys_n_d = 1'b0;
      cause_d = CausePll;
    end else if (btn_evt_q && (state_q inside {StSysHold, StRun, StWarm})) begin
      state_d = StPorHold;
      cnt_d   = '0;
      por_n_d = 1'b0;
      sys_n_d = 1'b0;
      cause_d = CauseBtn;
    end else begin
      unique case (state_q)
        StLockWait: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LockLast) begin
            state_d = StPorHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPorHold: begin
          // Counter saturates so a held button extends the hold indefinitely
          if (cnt_q != PorLast) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!deb_q) begin
            state_d = StSysHold;
            cnt_d   = '0;
            por_n_d = 1'b1;
          end
        end
        StSysHold: begin
          if (cnt_q == SysLast) begin
            state_d = StRun;
            cnt_d   = '0;
            sys_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (lockup_req) begin
            state_d = StWarm;
            cnt_d   = '0;
            sys_n_d = 1'b0;
            cause_d = CauseLockup;
          end else if (SYSRESETREQ) begin
            state_d = StWarm;
            cnt_d   = '0;
            sys_n_d = 1'b0;
            cause_d = CauseSysReq;
          end
        end
        StWarm: begin
          if (cnt_q != SysLast) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!warm_hold) begin
            state_d = StRun;
            cnt_d   = '0;
            sys_n_d = 1'b1;
          end
        end
        default: begin
          state_d = StLockWait;
          cnt_d   = '0;
          por_n_d = 1'b0;
          sys_n_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StLockWait;
      cnt_q   <= '0;
      por_n_q <= 1'b0;
      sys_n_q <= 1'b0;
      cause_q <= CausePin;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      por_n_q <= por_n_d;
      sys_n_q <= sys_n_d;
      cause_q <= cause_d;
    end
  end

  assign PORESETn  = por_n_q;
  assign SYSRESETn = sys_n_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl: power-up, lock glitch, warm resets, event priority,
// button debounce, PLL loss and asynchronous reset.
module tb_rst_ctrl;

  localparam int unsigned LockC = 4;
  localparam int unsigned PorC  = 8;
  localparam int unsigned SysC  = 3;
  localparam int unsigned DebC  = 8;

  logic       clk = 1'b0;
  logic       rst, pll, btn, req, lockup;
  logic       por_a, sys_a, por_b, sys_b;
  logic [4:0] cause_a, cause_b;

  int n_cmp  = 0;
  int n_bad  = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  rst_ctrl #(
    .LOCK_CYCLES    (LockC),
    .POR_CYCLES     (PorC),
    .SYS_CYCLES     (SysC),
    .DEBOUNCE_CYCLES(DebC),
    .LOCKUP_RST     (1'b1)
  ) dut_a (
    .CLK        (clk),
    .RESET      (rst),
    .PLL_LOCKED (pll),
    .BTN        (btn),
    .SYSRESETREQ(req),
    .LOCKUP     (lockup),
    .PORESETn   (por_a),
    .SYSRESETn  (sys_a),
    .RST_CAUSE  (cause_a)
  );

  rst_ctrl #(
    .LOCK_CYCLES    (LockC),
    .POR_CYCLES     (PorC),
    .SYS_CYCLES     (SysC),
    .DEBOUNCE_CYCLES(DebC),
    .LOCKUP_RST     (1'b0)
  ) dut_b (
    .CLK        (clk),
    .RESET      (rst),
    .PLL_LOCKED (pll),
    .BTN        (btn),
    .SYSRESETREQ(req),
    .LOCKUP     (lockup),
    .PORESETn   (por_b),
    .SYSRESETn  (sys_b),
    .RST_CAUSE  (cause_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic wait_run(input string tag, input int budget);
    int i;
    i = 0;
    while (sys_a !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    check_eq(tag, 32'(sys_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    pll    = 1'b1;
    btn    = 1'b0;
    req    = 1'b0;
    lockup = 1'b0;
    #2;
    check_eq("rst_por", 32'(por_a), 32'd0);
    check_eq("rst_sys", 32'(sys_a), 32'd0);
    check_eq("rst_cause", 32'(cause_a), 32'h01);
    check_eq("rst_cause_b", 32'(cause_b), 32'h01);

    // Release between edges so the next posedge is edge 1
    #10;
    rst    = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 13) check_eq("pwr_por_e13", 32'(por_a), 32'd0);
      if (e == 14) check_eq("pwr_por_e14", 32'(por_a), 32'd1);
      if (e == 14) check_eq("pwr_sys_e14", 32'(sys_a), 32'd0);
      if (e == 16) check_eq("pwr_sys_e16", 32'(sys_a), 32'd0);
      if (e == 17) check_eq("pwr_sys_e17", 32'(sys_a), 32'd1);
    end
    check_eq("pwr_cause", 32'(cause_a), 32'h01);
    check_eq("pwr_por_b", 32'(por_b), 32'd1);
    check_eq("pwr_sys_b", 32'(sys_b), 32'd1);

    // Single-cycle SYSRESETREQ pulse
    req = 1'b1;
    step();
    req = 1'b0;
    check_eq("warm_sys_k1", 32'(sys_a), 32'd0);
    check_eq("warm_por_k1", 32'(por_a), 32'd1);
    step();
    step();
    check_eq("warm_sys_k3", 32'(sys_a), 32'd0);
    check_eq("warm_por_k3", 32'(por_a), 32'd1);
    step();
    check_eq("warm_sys_k4", 32'(sys_a), 32'd1);
    check_eq("warm_cause", 32'(cause_a), 32'h08);

    // SYSRESETREQ held for 10 cycles stretches the warm reset
    req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) check_eq("warmhold_sys_5", 32'(sys_a), 32'd0);
      if (i == 10) check_eq("warmhold_sys_10", 32'(sys_a), 32'd0);
      if (i == 10) req = 1'b0;
    end
    step();
    check_eq("warmhold_release", 32'(sys_a), 32'd1);
    check_eq("warmhold_por", 32'(por_a), 32'd1);

    // LOCKUP and SYSRESETREQ together
    lockup = 1'b1;
    req    = 1'b1;
    step();
    lockup = 1'b0;
    req    = 1'b0;
    check_eq("simul_cause_a", 32'(cause_a), 32'h10);
    check_eq("simul_cause_b", 32'(cause_b), 32'h08);
    check_eq("simul_sys_a", 32'(sys_a), 32'd0);
    check_eq("simul_sys_b", 32'(sys_b), 32'd0);
    step();
    step();
    step();
    check_eq("simul_rel_a", 32'(sys_a), 32'd1);
    check_eq("simul_rel_b", 32'(sys_b), 32'd1);

    // PLL loss while in WARM
    req = 1'b1;
    step();
    check_eq("loss_in_warm", 32'(sys_a), 32'd0);
    pll = 1'b0;
    step();
    step();
    check_eq("loss_por_e2", 32'(por_a), 32'd1);
    step();
    check_eq("loss_por_e3", 32'(por_a), 32'd0);
    check_eq("loss_sys_e3", 32'(sys_a), 32'd0);
    check_eq("loss_cause", 32'(cause_a), 32'h04);
    req = 1'b0;

    // Relock with a one-cycle glitch: count restarts, PORESETn rises 3 edges late
    pll = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 2) pll = 1'b0;
      if (i == 3) pll = 1'b1;
      if (i == 16) check_eq("glitch_por_16", 32'(por_a), 32'd0);
      if (i == 17) check_eq("glitch_por_17", 32'(por_a), 32'd1);
      if (i == 19) check_eq("glitch_sys_19", 32'(sys_a), 32'd0);
      if (i == 20) check_eq("glitch_sys_20", 32'(sys_a), 32'd1);
    end
    check_eq("glitch_cause", 32'(cause_a), 32'h04);

    // 5-cycle bounce is rejected
    btn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    btn = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check_eq("bounce_por", 32'(por_a), 32'd1);
    check_eq("bounce_sys", 32'(sys_a), 32'd1);
    check_eq("bounce_cause", 32'(cause_a), 32'h04);

    // 12-cycle press: resets drop 11 edges after BTN rises
    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 10) check_eq("btn12_por_10", 32'(por_a), 32'd1);
      if (i == 11) check_eq("btn12_por_11", 32'(por_a), 32'd0);
      if (i == 11) check_eq("btn12_sys_11", 32'(sys_a), 32'd0);
      if (i == 11) check_eq("btn12_cause", 32'(cause_a), 32'h02);
    end
    btn = 1'b0;
    wait_run("btn12_recover", 80);

    // 50-cycle press: POR hold extends until the debounced release
    btn = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 11) check_eq("btn50_por_11", 32'(por_a), 32'd0);
      if (i == 50) btn = 1'b0;
      if (i == 58) check_eq("btn50_por_58", 32'(por_a), 32'd0);
      if (i == 60) check_eq("btn50_por_60", 32'(por_a), 32'd0);
      if (i == 61) check_eq("btn50_por_61", 32'(por_a), 32'd1);
      if (i == 63) check_eq("btn50_sys_63", 32'(sys_a), 32'd0);
      if (i == 64) check_eq("btn50_sys_64", 32'(sys_a), 32'd1);
    end
    check_eq("btn50_cause", 32'(cause_a), 32'h02);

    // Asynchronous RESET between edges
    step();
    check_eq("async_pre_por", 32'(por_a), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_por", 32'(por_a), 32'd0);
    check_eq("async_sys", 32'(sys_a), 32'd0);
    check_eq("async_cause", 32'(cause_a), 32'h01);
    #2;
    rst = 1'b0;
    step();
    step();
    check_eq("async_restart_por", 32'(por_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
